// File: rtl/div_pkg.sv
// Shared definitions for the sequential non-restoring divider.
//   state_e : controller states (2-bit encoding)
//   neg_n   : two's-complement negation on a wide vector (callers truncate)
//   abs_n   : conditional magnitude; negates only when told the value is negative
package div_pkg;

    localparam int unsigned ST_W  = 2;
    localparam int unsigned MAX_W = 64;   // widest operand the helpers support

    localparam logic [ST_W-1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [ST_W-1:0] ST_ITER_ENC = 2'd1;
    localparam logic [ST_W-1:0] ST_FIX_ENC  = 2'd2;
    localparam logic [ST_W-1:0] ST_DONE_ENC = 2'd3;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_ITER = ST_ITER_ENC,
        ST_FIX  = ST_FIX_ENC,
        ST_DONE = ST_DONE_ENC
    } state_e;

    function automatic logic [MAX_W-1:0] neg_n(input logic [MAX_W-1:0] x);
        return ~x + 1'b1;
    endfunction

    // The caller supplies "is negative" (in_signed & msb) so the helper
    // stays width-agnostic; the low N bits of the result are the magnitude.
    function automatic logic [MAX_W-1:0] abs_n(input logic [MAX_W-1:0] x,
                                               input logic             is_neg);
        return is_neg ? neg_n(x) : x;
    endfunction

endpackage

// File: rtl/nr_div_step.sv
// One combinational non-restoring iteration.
//   a_i [N:0]   partial remainder (two's complement, N+1 bits)
//   q_i [N-1:0] quotient/dividend shift register
//   d_i [N-1:0] divisor magnitude
//   a_o, q_o    values after shift, add/subtract and quotient-bit insert
module nr_div_step #(
    parameter int N = 8
) (
    input  logic [N:0]   a_i,
    input  logic [N-1:0] q_i,
    input  logic [N-1:0] d_i,
    output logic [N:0]   a_o,
    output logic [N-1:0] q_o
);

    logic [N:0] a_sh;
    logic [N:0] d_ext;

    assign a_sh  = {a_i[N-1:0], q_i[N-1]};
    assign d_ext = {1'b0, d_i};

    // The add/subtract choice uses the sign before the shift; the shifted
    // value may wrap, but the result lands back in [-D, D) modulo 2^(N+1).
    assign a_o = a_i[N] ? (a_sh + d_ext) : (a_sh - d_ext);
    assign q_o = {q_i[N-2:0], ~a_o[N]};

endmodule

// File: rtl/seq_nonrestoring_divider.sv
// Multi-cycle non-restoring integer divider, one quotient bit per clock.
//   clk, rst (sync, active-low)
//   in_valid/in_ready, in_signed, dividend, divisor : operand handshake
//   out_valid/out_ready, quotient, remainder         : result handshake
//   div_zero : divisor was zero (q = all ones, r = raw dividend)
//   ovf      : signed MIN / -1 (q = MIN, r = 0)
module seq_nonrestoring_divider
    import div_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_signed,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_zero,
    output logic         ovf
);

    localparam int CNT_W = $clog2(N + 1);
    localparam logic [N-1:0] MIN_V = {1'b1, {(N-1){1'b0}}};

    state_e         state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N:0]     a_q;
    logic [N-1:0]   q_q;
    logic [N-1:0]   d_q;
    logic           neg_quo_q;
    logic           neg_rem_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic [N-1:0]   quotient_q;
    logic [N-1:0]   remainder_q;
    logic           div_zero_q;
    logic           ovf_q;

    logic [N-1:0]   abs_dvd_d;
    logic [N-1:0]   abs_dvs_d;
    logic           is_ovf_d;
    logic [N:0]     a_d;
    logic [N-1:0]   q_d;
    logic [N-1:0]   rem_mag_d;
    logic [N-1:0]   quo_fix_d;
    logic [N-1:0]   rem_fix_d;

    assign abs_dvd_d = N'(abs_n(MAX_W'(dividend), in_signed & dividend[N-1]));
    assign abs_dvs_d = N'(abs_n(MAX_W'(divisor),  in_signed & divisor[N-1]));
    assign is_ovf_d  = in_signed && (dividend == MIN_V) && (divisor == '1);

    nr_div_step #(.N(N)) u_step (
        .a_i (a_q),
        .q_i (q_q),
        .d_i (d_q),
        .a_o (a_d),
        .q_o (q_d)
    );

    // Final restore: a negative partial remainder lies in [-D, 0), so adding
    // D back only needs the low N bits.
    assign rem_mag_d = a_q[N] ? (a_q[N-1:0] + d_q) : a_q[N-1:0];
    assign quo_fix_d = neg_quo_q ? N'(neg_n(MAX_W'(q_q)))      : q_q;
    assign rem_fix_d = neg_rem_q ? N'(neg_n(MAX_W'(rem_mag_d))) : rem_mag_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        if (divisor == '0) begin
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            div_zero_q  <= 1'b1;
                            ovf_q       <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else if (is_ovf_d) begin
                            quotient_q  <= MIN_V;
                            remainder_q <= '0;
                            div_zero_q  <= 1'b0;
                            ovf_q       <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            a_q       <= '0;
                            q_q       <= abs_dvd_d;
                            d_q       <= abs_dvs_d;
                            cnt_q     <= '0;
                            neg_quo_q <= in_signed & (dividend[N-1] ^ divisor[N-1]);
                            neg_rem_q <= in_signed & dividend[N-1];
                            state_q   <= ST_ITER;
                        end
                    end
                end
                ST_ITER: begin
                    a_q   <= a_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(N - 1)) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    quotient_q  <= quo_fix_d;
                    remainder_q <= rem_fix_d;
                    div_zero_q  <= 1'b0;
                    ovf_q       <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_nonrestoring_divider.sv
// Randomised and directed bench for seq_nonrestoring_divider (N = 8),
// compared against a plain-arithmetic reference model.
module tb_seq_nonrestoring_divider;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_signed;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_zero;
    logic         ovf;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_nonrestoring_divider #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division with truncation toward zero.
    function automatic void ref_div(input logic [N-1:0] x, input logic [N-1:0] y,
                                    input logic s,
                                    output logic [N-1:0] q, output logic [N-1:0] r,
                                    output logic dz, output logic ov, output int lat);
        int sx;
        int sy;
        dz  = 1'b0;
        ov  = 1'b0;
        lat = N + 2;
        if (y == 0) begin
            q = '1; r = x; dz = 1'b1; lat = 1;
        end else if (s && x == 8'h80 && y == 8'hFF) begin
            q = 8'h80; r = '0; ov = 1'b1; lat = 1;
        end else if (s) begin
            sx = $signed(x);
            sy = $signed(y);
            q  = N'(sx / sy);
            r  = N'(sx % sy);
        end else begin
            q = x / y;
            r = x % y;
        end
    endfunction

    // Caller is positioned #1 after a rising edge with the divider idle.
    task automatic do_op(input logic [N-1:0] x, input logic [N-1:0] y,
                         input logic s, input int hold);
        logic [N-1:0] eq, er;
        logic         edz, eov;
        int           elat;
        int           k;
        logic [2*N+1:0] snap;
        ref_div(x, y, s, eq, er, edz, eov, elat);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_signed = s;
        dividend  = x;
        divisor   = y;
        out_ready = 1'b0;
        @(posedge clk); #1;
        // Keep poking the busy divider with junk; it must be ignored.
        dividend = N'($urandom);
        divisor  = N'($urandom);
        k = 0;
        while (!out_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        in_valid = 1'b0;
        chk("latency", 32'(k + 1), 32'(elat));
        chk("quotient", 32'(quotient), 32'(eq));
        chk("remainder", 32'(remainder), 32'(er));
        chk("div_zero", 32'(div_zero), 32'(edz));
        chk("ovf", 32'(ovf), 32'(eov));
        chk("in_ready_busy", 32'(in_ready), 32'd0);
        snap = {quotient, remainder, div_zero, ovf};
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_stable", 32'({quotient, remainder, div_zero, ovf}), 32'(snap));
            chk("hold_valid", 32'({out_valid, in_ready}), 32'b10);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release", 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", 32'({out_valid, quotient, remainder, div_zero, ovf}), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;

        do_op(8'd200, 8'd7,   1'b0, 0);
        chk("200/7_q_const", 32'(quotient), 32'd28);
        chk("200/7_r_const", 32'(remainder), 32'd4);
        do_op(8'h9C,  8'd7,   1'b1, 1);   // -100 / 7
        chk("-100/7_q_const", 32'(quotient), 32'hF2);
        do_op(8'd100, 8'hF9,  1'b1, 0);   // 100 / -7
        do_op(8'd55,  8'd0,   1'b0, 2);
        do_op(8'h80,  8'hFF,  1'b1, 0);   // MIN / -1
        do_op(8'd128, 8'd255, 1'b0, 0);
        do_op(8'h80,  8'd0,   1'b1, 0);   // signed divide-by-zero
        do_op(8'd77,  8'd5,   1'b0, 5);
        do_op(8'd13,  8'd3,   1'b0, 0);

        // Abort in the middle of the iterations.
        in_valid  = 1'b1;
        in_signed = 1'b0;
        dividend  = 8'd200;
        divisor   = 8'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("abort_outputs", 32'({out_valid, quotient, remainder, div_zero, ovf}), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        do_op(8'd9, 8'd2, 1'b0, 0);

        for (int i = 0; i < 150; i++) begin
            logic [N-1:0] x, y;
            x = N'($urandom);
            y = ($urandom_range(0, 9) == 0) ? 8'd0 : N'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                x = 8'h80;
                y = 8'hFF;
            end
            do_op(x, y, 1'($urandom), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
